// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int FRAME_BITS         = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle o_tick every DIV clocks.
// i_restart re-phases the counter so ticks line up with a detected start edge.
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(DIV - 1));

  // Free-running divider, wraps after DIV-1, forced to zero on restart.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling, valid/ready output,
// frame-error and overrun pulses.
//
// Output handshake: o_valid rises when a byte lands in o_data and stays high
// until a cycle where o_valid && i_ready; that cycle consumes the byte. A new
// byte arriving in that same cycle keeps o_valid high without an overrun; a new
// byte arriving while o_valid is high and i_ready is low overwrites o_data and
// pulses o_overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       uart_txd_in,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy,
  output logic [1:0] o_dbg_state
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(FRAME_BITS);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

  uart_state_t           r_state;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [TW-1:0]         r_tick_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [7:0]            r_data;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_overrun;

  logic w_rx;
  logic w_tick;
  logic w_restart;

  assign w_rx      = r_sync2;
  assign w_restart = (r_state == ST_IDLE) && !w_rx;

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud_gen (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Two-flop synchronizer for the asynchronous serial line, idles high.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_txd_in;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM plus output register handling (valid, pulses, data).
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_rx) begin
            r_state    <= ST_START;
            r_tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_tick_cnt == HALF_LAST) begin
              r_tick_cnt <= '0;
              if (!w_rx) begin
                r_state   <= ST_DATA;
                r_bit_cnt <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == FULL_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rx, r_shift[FRAME_BITS-1:1]};
              r_bit_cnt  <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == BIT_LAST) begin
                r_state <= ST_STOP;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == FULL_LAST) begin
              r_tick_cnt <= '0;
              r_state    <= ST_IDLE;
              if (w_rx) begin
                r_data    <= r_shift[7:0];
                r_valid   <= 1'b1;
                r_overrun <= r_valid && !i_ready;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1.6 MHz / 10 kbaud / x16 (160 clocks per bit).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 160;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       i_reset;
  logic       uart_txd_in;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;
  logic [1:0] o_dbg_state;

  always #5 clock = ~clock;

  uart_rx #(
    .CLK_FREQ   (1600000),
    .BAUD       (10000),
    .OVERSAMPLE (16)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .uart_txd_in (uart_txd_in),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- monitor (event counters) ----------------
  int         n_valid_cyc = 0;
  int         n_err       = 0;
  int         n_ovr       = 0;
  logic [7:0] last_seen   = 8'h00;

  always @(negedge clock) begin
    if (o_valid) begin
      n_valid_cyc = n_valid_cyc + 1;
      last_seen   = o_data;
    end
    if (o_frame_err) n_err = n_err + 1;
    if (o_overrun)   n_ovr = n_ovr + 1;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input int n);
    uart_txd_in = v;
    repeat (n) @(negedge clock);
  endtask

  // stop_ok=0 holds the stop bit low long enough to cover its mid-bit sample.
  task automatic send_byte(input logic [7:0] d, input logic stop_ok);
    @(negedge clock);
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive(d[i], BIT_CLKS);
    if (stop_ok) begin
      drive(1'b1, BIT_CLKS);
    end else begin
      drive(1'b0, 100);
      drive(1'b1, BIT_CLKS);
    end
  endtask

  int b_valid, b_err, b_ovr;

  task automatic snap();
    b_valid = n_valid_cyc;
    b_err   = n_err;
    b_ovr   = n_ovr;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    i_reset     = 1'b1;
    uart_txd_in = 1'b1;
    i_ready     = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_data",  {24'd0, o_data}, 32'h00);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_ferr",  {31'd0, o_frame_err}, 32'd0);
    check("rst_ovr",   {31'd0, o_overrun}, 32'd0);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    check("rst_state", {30'd0, o_dbg_state}, {30'd0, ST_IDLE});
    i_reset = 1'b0;
    repeat (20) @(negedge clock);

    // Frame 0xA5, consumer always ready.
    i_ready = 1'b1;
    snap();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    repeat (200) @(negedge clock);
    check("a5_valid_cycles", n_valid_cyc - b_valid, 1);
    check("a5_seen",  {24'd0, last_seen}, {24'd0, exp_q[0]});
    check("a5_data",  {24'd0, o_data}, {24'd0, exp_q.pop_front()});
    check("a5_ferr",  n_err - b_err, 0);
    check("a5_ovr",   n_ovr - b_ovr, 0);
    check("a5_valid_now", {31'd0, o_valid}, 32'd0);

    // 40-clock low glitch on an idle line.
    snap();
    @(negedge clock);
    drive(1'b0, 20);
    check("glitch_busy", {31'd0, o_busy}, 32'd1);
    drive(1'b0, 20);
    drive(1'b1, 300);
    check("glitch_state", {30'd0, o_dbg_state}, {30'd0, ST_IDLE});
    check("glitch_busy_end", {31'd0, o_busy}, 32'd0);
    check("glitch_valid", n_valid_cyc - b_valid, 0);
    check("glitch_ferr",  n_err - b_err, 0);

    // Frame 0x3C with low stop bit: error, data keeps 0xA5.
    snap();
    send_byte(8'h3C, 1'b0);
    repeat (300) @(negedge clock);
    check("ferr_pulses", n_err - b_err, 1);
    check("ferr_data",   {24'd0, o_data}, 32'hA5);
    check("ferr_valid",  n_valid_cyc - b_valid, 0);
    check("ferr_ovr",    n_ovr - b_ovr, 0);

    // 0x11 then 0x22 back-to-back, consumer stalled.
    i_ready = 1'b0;
    snap();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (200) @(negedge clock);
    check("b2b_valid", {31'd0, o_valid}, 32'd1);
    check("b2b_ovr",   n_ovr - b_ovr, 1);
    check("b2b_data",  {24'd0, o_data}, 32'h22);
    check("b2b_ferr",  n_err - b_err, 0);

    // Reset in bit 4 of 0x5A, then frame 0x81.
    i_ready = 1'b1;
    repeat (5) @(negedge clock);
    snap();
    @(negedge clock);
    drive(1'b0, BIT_CLKS);
    drive(1'b0, BIT_CLKS);  // bit0 of 0x5A
    drive(1'b1, BIT_CLKS);  // bit1
    drive(1'b0, BIT_CLKS);  // bit2
    drive(1'b1, BIT_CLKS);  // bit3
    drive(1'b1, 80);        // into bit4
    i_reset = 1'b1;
    repeat (3) @(negedge clock);
    check("midrst_busy",  {31'd0, o_busy}, 32'd0);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_data",  {24'd0, o_data}, 32'h00);
    i_reset = 1'b0;
    drive(1'b1, 400);
    send_byte(8'h81, 1'b1);
    repeat (200) @(negedge clock);
    check("after_rst_valid_cycles", n_valid_cyc - b_valid, 1);
    check("after_rst_seen", {24'd0, last_seen}, 32'h81);
    check("after_rst_data", {24'd0, o_data}, 32'h81);
    check("after_rst_ferr", n_err - b_err, 0);

    // Consume on the exact cycle the next byte loads.
    i_ready = 1'b0;
    send_byte(8'h33, 1'b1);
    repeat (200) @(negedge clock);
    check("pre_valid", {31'd0, o_valid}, 32'd1);
    check("pre_data",  {24'd0, o_data}, 32'h33);
    snap();
    fork
      send_byte(8'h44, 1'b1);
      begin
        // Load lands on the 1523rd rising edge after the start-bit negedge.
        repeat (1523) @(negedge clock);
        check("same_cycle_valid_before", {31'd0, o_valid}, 32'd1);
        i_ready = 1'b1;
        @(negedge clock);
        i_ready = 1'b0;
        check("same_cycle_valid_after", {31'd0, o_valid}, 32'd1);
      end
    join
    repeat (50) @(negedge clock);
    check("same_cycle_valid", {31'd0, o_valid}, 32'd1);
    check("same_cycle_data",  {24'd0, o_data}, 32'h44);
    check("same_cycle_ovr",   n_ovr - b_ovr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, meaning the clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, meaning the serial bit rate in bit/s.
REQ-003 Parameter OVERSAMPLE, default 16, meaning sample ticks per bit (even, >= 8).
REQ-004 clock  input  1  is the single system clock; all logic SHALL be rising-edge.
REQ-005 i_reset  input  1  is the reset: asynchronous, active-high.
REQ-006 uart_txd_in  input  1  is the asynchronous serial line: 8N1, LSB first, idle high.
REQ-007 o_data  output  8  is the last received byte.
REQ-008 o_valid  output  1  is high while o_data holds an unconsumed byte.
REQ-009 i_ready  input  1  is the consumer acknowledge; o_valid && i_ready consumes the byte.
REQ-010 o_frame_err  output  1  is a one-cycle pulse when the stop bit is sampled low.
REQ-011 o_overrun  output  1  is a one-cycle pulse when an unconsumed byte is overwritten.
REQ-012 o_busy  output  1  is high whenever the FSM is not in IDLE.

Function
REQ-013 uart_txd_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized line (2-cycle latency).
REQ-014 Tick divisor SHALL be DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated; one-cycle tick every DIV clocks; counter width $clog2(DIV).
REQ-015 The tick counter SHALL restart from 0 on the IDLE->START transition, aligning sampling to the detected falling edge.
REQ-016 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-017 IDLE: synchronized line low -> START.
REQ-018 START: after OVERSAMPLE/2 ticks, line low -> DATA with the sample count cleared; line high -> IDLE (glitch reject, no outputs).
REQ-019 DATA: every OVERSAMPLE ticks sample one bit into the shift register LSB first; after the 8th bit -> STOP.
REQ-020 STOP: after OVERSAMPLE ticks (mid stop bit), line high -> load o_data, assert o_valid; line low -> pulse o_frame_err, o_data/o_valid unchanged; both cases -> IDLE the next cycle.
REQ-021 A new start edge SHALL be accepted from the first IDLE cycle following STOP (back-to-back frames).
REQ-022 o_valid SHALL clear the cycle after o_valid && i_ready unless a new byte loads in that same cycle.
REQ-023 Byte completes while o_valid high and i_ready low -> overwrite o_data, keep o_valid high, pulse o_overrun.
REQ-024 Byte completes in the same cycle as o_valid && i_ready -> load new byte, o_valid stays high, no o_overrun.
REQ-025 Line held low through a full frame (break) SHALL produce o_frame_err, then return to IDLE and restart START qualification only on the next low level.
REQ-026 i_ready while o_valid low SHALL have no effect.

Reset
REQ-027 i_reset high SHALL immediately force IDLE, o_data=8'h00, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0, synchronizer flops=1, counters=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte; after release the block waits for a fresh falling edge.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state encoding, the frame length constant (8) and the OVERSAMPLE default.
REQ-030 Tick generation SHALL be the sub-module uart_baud_gen (inputs clock, i_reset, i_restart; output o_tick).

Verification (CLK_FREQ=1600000, BAUD=10000, OVERSAMPLE=16 -> DIV=10, 160 clocks/bit)
REQ-031 Frame 0xA5 with i_ready held high -> o_data=8'hA5, o_valid high one cycle, no error pulses.
REQ-032 Low glitch of 40 clocks on an idle line -> FSM returns to IDLE, o_valid/o_frame_err stay 0.
REQ-033 Frame 0x3C with stop bit low -> one o_frame_err pulse; o_data keeps its previous value.
REQ-034 Frames 0x11 then 0x22 back-to-back, i_ready low -> o_valid high, o_overrun pulses once, o_data=8'h22.
REQ-035 i_reset pulsed during bit 4 of 0x5A, then frame 0x81 -> only 0x81 is delivered.
REQ-036 i_ready asserted on the exact cycle a second byte loads -> o_valid stays high, no o_overrun.
